// File: rtl/fp_acc_seq.sv
// fp_acc_seq: sums a stream of IEEE-754 single-precision values into one scalar.
// Each element goes through one round trip of the pipelined fp_add. The accumulator
// is fed back as operand A, and the next element is accepted only after the sum returns.
//
// fp_add: pipelined single-precision adder with round-to-nearest-even.
// q carries the sum of a/b exactly LATENCY clocks after they change (en=1).
// Denormals are handled, and NaN results are the canonical quiet NaN.

module fp_add #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);

  logic        sa, sb, sl, ss;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [9:0]  el, es, ediff, e_n, lz, sh;
  logic [23:0] ml, ms;
  logic [26:0] ml_x, ms_x, norm;
  logic [27:0] sum;
  logic [24:0] m_r;
  logic        rnd;
  logic [7:0]  e_f;
  logic [31:0] res;

  // Right shift with guard/round/sticky. Bits shifted out are ORed into the LSB.
  function automatic logic [26:0] shr_sticky(input logic [26:0] x, input logic [9:0] d);
    logic [26:0] r;
    logic [26:0] lost;
    if (d >= 10'd27) begin
      r = {26'd0, |x};
    end else begin
      r    = x >> d;
      lost = x & ((27'd1 << d) - 27'd1);
      r    = {r[26:1], r[0] | (|lost)};
    end
    return r;
  endfunction

  function automatic logic [9:0] lzc(input logic [26:0] x);
    logic [9:0] n;
    logic       found;
    n     = 10'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = 10'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Combinational add: align, add/sub, normalise, round, then patch special values.
  always_comb begin
    sa    = a[31];
    sb    = b[31];
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);
    if (a[30:0] >= b[30:0]) begin
      sl = sa;
      ss = sb;
      el = (a[30:23] == 8'd0) ? 10'd1 : {2'b00, a[30:23]};
      es = (b[30:23] == 8'd0) ? 10'd1 : {2'b00, b[30:23]};
      ml = {|a[30:23], a[22:0]};
      ms = {|b[30:23], b[22:0]};
    end else begin
      sl = sb;
      ss = sa;
      el = (b[30:23] == 8'd0) ? 10'd1 : {2'b00, b[30:23]};
      es = (a[30:23] == 8'd0) ? 10'd1 : {2'b00, a[30:23]};
      ml = {|b[30:23], b[22:0]};
      ms = {|a[30:23], a[22:0]};
    end
    ediff = el - es;
    ml_x  = {ml, 3'b000};
    ms_x  = shr_sticky({ms, 3'b000}, ediff);
    if (sl == ss) sum = {1'b0, ml_x} + {1'b0, ms_x};
    else          sum = {1'b0, ml_x} - {1'b0, ms_x};
    lz = '0;
    sh = '0;
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e_n  = el + 10'd1;
    end else begin
      // Left shift is capped so the exponent never drops below 1 (denormal result).
      lz   = lzc(sum[26:0]);
      sh   = (lz > el - 10'd1) ? el - 10'd1 : lz;
      norm = sum[26:0] << sh;
      e_n  = el - sh;
    end
    rnd = norm[2] & (norm[3] | norm[1] | norm[0]);
    m_r = {1'b0, norm[26:3]} + {24'd0, rnd};
    if (m_r[24]) begin
      m_r = {1'b0, m_r[24:1]};
      e_n = e_n + 10'd1;
    end
    // No hidden bit means the result is denormal. Rounding into bit 23 promotes it to exponent 1.
    e_f = m_r[23] ? e_n[7:0] : 8'd0;
    if (a_nan | b_nan | (a_inf & b_inf & (sa ^ sb))) res = 32'h7FC00000;
    else if (a_inf)                                   res = a;
    else if (b_inf)                                   res = b;
    else if (sum == 28'd0)                            res = {sl & ss, 31'd0};
    else if (m_r[23] && (e_n >= 10'd255))             res = {sl, 8'hFF, 23'd0};
    else                                              res = {sl, e_f, m_r[22:0]};
  end

  if (LATENCY == 0) begin : g_comb
    assign q = res;
  end else begin : g_pipe
    logic [31:0] pipe_q [LATENCY];
    // Delay line that models the IP pipeline depth.
    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else if (en) begin
        pipe_q[0] <= res;
        for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign q = pipe_q[LATENCY-1];
  end

endmodule

// state  | meaning
// IDLE   | waiting for start; out_data keeps the last result
// ACCEPT | in_ready high, waiting for the next element
// WAIT   | operands held on fp_add until its sum returns
// DONE   | out_valid high until out_ready

module fp_acc_seq #(
  parameter int ADD_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam int WCNT_W = ($clog2(ADD_LATENCY + 1) < 1) ? 1 : $clog2(ADD_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WAIT, S_DONE} state_t;

  state_t            state_q;
  logic [31:0]       acc_q, opa_q, opb_q, out_data_q;
  logic [CNT_W-1:0]  rem_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              in_ready_q, out_valid_q, busy_q;
  logic [31:0]       add_q;

  fp_add #(.LATENCY(ADD_LATENCY)) u_add (
    .clk    (clk),
    .areset (~areset_n),
    .en     (1'b1),
    .a      (opa_q),
    .b      (opb_q),
    .q      (add_q)
  );

  // Sequencer with registered handshake outputs. The sum is captured when the wait counter hits the adder latency.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      out_data_q  <= '0;
      rem_q       <= '0;
      wcnt_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q  <= '0;
            busy_q <= 1'b1;
            if (len != '0) begin
              rem_q      <= len;
              in_ready_q <= 1'b1;
              state_q    <= S_ACCEPT;
            end else begin
              out_data_q  <= '0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            opa_q      <= acc_q;
            opb_q      <= in_data;
            rem_q      <= rem_q - CNT_W'(1);
            wcnt_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q + WCNT_W'(1);
          if (wcnt_q == WCNT_W'(ADD_LATENCY)) begin
            acc_q <= add_q;
            if (rem_q == '0) begin
              out_data_q  <= add_q;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_ACCEPT;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
